mem_access_ctrl: RTL and testbench

Memory-stage access controller for the 5-stage RV32I pipeline. It decodes the load/store held in the EX/MEM pipeline register, sequences a single-outstanding request/grant/response transaction on the data-memory bus and freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) until the access completes. It also formats store data and byte masks, sign/zero-extends load data for writeback, and reports misalignment and bus timeouts.

---
 rtl/mem_access_ctrl_if.sv | 49 ++++
 rtl/mem_access_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Data-memory bus between the MEM-stage access controller and the memory.
// One transaction is outstanding at a time: request/grant, then a response.
//
// Signals
//   mem_req     controller -> memory  request valid; address/data held stable
//   mem_we      controller -> memory  1 = store, 0 = load (0 when mem_req = 0)
//   mem_addr    controller -> memory  word-aligned byte address
//   mem_wdata   controller -> memory  lane-replicated store data
//   mem_wmask   controller -> memory  byte enables (0 for loads)
//   mem_gnt     memory -> controller  request accepted this cycle
//   mem_rvalid  memory -> controller  response valid this cycle
//   mem_rdata   memory -> controller  response word
//
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// MEM-stage access controller for the 5-stage RV32I pipeline. It decodes the
// load/store held in EX/MEM, runs one request/grant/response transaction on
// the data bus, and freezes the upstream pipeline until the access finishes.
// It also formats store data and byte masks, extends load data, and flags
// misaligned/illegal accesses and bus timeouts.
//
// Parameters
//   TIMEOUT        maximum REQ+WAIT cycles before abort (1..1023)
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   valid_m        EX/MEM holds a real instruction
//   instr_opcodeM  opcode from EX/MEM
//   funct3M        funct3 from EX/MEM
//   ALUResultM     effective byte address
//   rdata2M        store source data
//   stall          freeze PC and pipeline registers up to EX/MEM
//   bus            data-memory bus (master side)
//   load_data      extended load result (registered)
//   load_valid     load_data valid this cycle (registered)
//   fault          misaligned or illegal access this cycle (combinational)
//   bus_err        access aborted by timeout (registered)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_m,
  input  logic [6:0]                instr_opcodeM,
  input  logic [2:0]                funct3M,
  input  logic [31:0]               ALUResultM,
  input  logic [31:0]               rdata2M,
  output logic                      stall,
  mem_access_ctrl_if.master         bus,
  output logic [31:0]               load_data,
  output logic                      load_valid,
  output logic                      fault,
  output logic                      bus_err
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Counter value seen in the last allowed REQ/WAIT cycle.
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [9:0]  cnt_r;
  logic        ld_r;
  logic [31:0] load_data_r;
  logic        load_valid_r;
  logic        bus_err_r;

  logic        is_ld_op_s;
  logic        is_st_op_s;
  logic        legal_s;
  logic        misalign_s;
  logic        mem_op_s;
  logic        access_ok_s;
  logic        fault_s;
  logic        stall_s;
  logic        mem_req_s;
  logic        capture_s;
  logic        abort_s;
  logic        last_s;
  logic [31:0] wdata_s;
  logic [3:0]  wmask_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;

  assign is_ld_op_s  = (instr_opcodeM == OP_LOAD);
  assign is_st_op_s  = (instr_opcodeM == OP_STORE);
  assign mem_op_s    = valid_m & (is_ld_op_s | is_st_op_s);
  assign access_ok_s = mem_op_s & legal_s & ~misalign_s;
  assign last_s      = (cnt_r >= TO_LAST);

  // Legality and alignment of the load/store held in EX/MEM.
  always_comb begin
    legal_s    = 1'b0;
    misalign_s = 1'b0;
    if (is_ld_op_s) begin
      case (funct3M)
        3'b000, 3'b100: begin
          legal_s    = 1'b1;
          misalign_s = 1'b0;
        end
        3'b001, 3'b101: begin
          legal_s    = 1'b1;
          misalign_s = ALUResultM[0];
        end
        3'b010: begin
          legal_s    = 1'b1;
          misalign_s = |ALUResultM[1:0];
        end
        default: begin
          legal_s    = 1'b0;
          misalign_s = 1'b0;
        end
      endcase
    end else if (is_st_op_s) begin
      case (funct3M)
        3'b000: begin
          legal_s    = 1'b1;
          misalign_s = 1'b0;
        end
        3'b001: begin
          legal_s    = 1'b1;
          misalign_s = ALUResultM[0];
        end
        3'b010: begin
          legal_s    = 1'b1;
          misalign_s = |ALUResultM[1:0];
        end
        default: begin
          legal_s    = 1'b0;
          misalign_s = 1'b0;
        end
      endcase
    end else begin
      legal_s    = 1'b0;
      misalign_s = 1'b0;
    end
  end

  // Store data lane replication and byte-enable generation.
  always_comb begin
    wdata_s = 32'h0000_0000;
    wmask_s = 4'b0000;
    case (funct3M)
      3'b000: begin
        wdata_s = {4{rdata2M[7:0]}};
        wmask_s = 4'b0001 << ALUResultM[1:0];
      end
      3'b001: begin
        wdata_s = {2{rdata2M[15:0]}};
        wmask_s = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      3'b010: begin
        wdata_s = rdata2M;
        wmask_s = 4'b1111;
      end
      default: begin
        wdata_s = 32'h0000_0000;
        wmask_s = 4'b0000;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the response word.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    ext_s  = 32'h0000_0000;
    case (ALUResultM[1:0])
      2'b00:   byte_s = bus.mem_rdata[7:0];
      2'b01:   byte_s = bus.mem_rdata[15:8];
      2'b10:   byte_s = bus.mem_rdata[23:16];
      2'b11:   byte_s = bus.mem_rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = ALUResultM[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3M)
      3'b000:  ext_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  ext_s = {{16{half_s[15]}}, half_s};
      3'b010:  ext_s = bus.mem_rdata;
      3'b100:  ext_s = {24'h00_0000, byte_s};
      3'b101:  ext_s = {16'h0000, half_s};
      default: ext_s = 32'h0000_0000;
    endcase
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    mem_req_s  = 1'b0;
    fault_s    = 1'b0;
    capture_s  = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Faults never stall: the offending instruction simply moves on.
        fault_s = mem_op_s & ~(legal_s & ~misalign_s);
        if (access_ok_s) begin
          stall_s    = 1'b1;
          state_nx_s = ST_REQ;
        end else begin
          stall_s    = 1'b0;
          state_nx_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
        // A grant in the final allowed cycle still aborts: no budget is left
        // for the response.
        if (last_s) begin
          abort_s    = 1'b1;
          state_nx_s = ST_DONE;
        end else if (bus.mem_gnt) begin
          state_nx_s = ST_WAIT;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        stall_s = 1'b1;
        // A response arriving together with the timeout wins.
        if (bus.mem_rvalid) begin
          capture_s  = 1'b1;
          state_nx_s = ST_DONE;
        end else if (last_s) begin
          abort_s    = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        stall_s    = 1'b0;
        state_nx_s = ST_IDLE;
      end
      default: begin
        stall_s    = 1'b0;
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Timeout counter: cleared when an access starts, counts REQ/WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 10'd0;
    end else if (state_r == ST_IDLE) begin
      cnt_r <= 10'd0;
    end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
      cnt_r <= cnt_r + 10'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Remember the access kind when the transaction is launched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && access_ok_s) begin
      ld_r <= is_ld_op_s;
    end else begin
      ld_r <= ld_r;
    end
  end

  // Load result register plus the DONE-cycle status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_data_r  <= 32'h0000_0000;
      load_valid_r <= 1'b0;
      bus_err_r    <= 1'b0;
    end else begin
      load_valid_r <= capture_s & ld_r;
      bus_err_r    <= abort_s;
      if (capture_s && ld_r) begin
        load_data_r <= ext_s;
      end else if (abort_s) begin
        load_data_r <= 32'h0000_0000;
      end else begin
        load_data_r <= load_data_r;
      end
    end
  end

  assign stall         = stall_s;
  assign fault         = fault_s;
  assign load_data     = load_data_r;
  assign load_valid    = load_valid_r;
  assign bus_err       = bus_err_r;

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = mem_req_s & ~ld_r;
  assign bus.mem_addr  = {ALUResultM[31:2], 2'b00};
  assign bus.mem_wdata = wdata_s;
  assign bus.mem_wmask = is_st_op_s ? wmask_s : 4'b0000;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. Each access pushes its expected
// outcome into a scoreboard queue; the entry is popped and compared in the
// cycle where the controller releases the pipeline.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int TO = 8;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_m;
  logic [6:0]  instr_opcodeM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] rdata2M;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        fault;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        ld;
    int          stalls;
    int          reqs;
  } exp_t;

  exp_t sb_q[$];

  mem_access_ctrl_if bus_if ();

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_m       (valid_m),
    .instr_opcodeM (instr_opcodeM),
    .funct3M       (funct3M),
    .ALUResultM    (ALUResultM),
    .rdata2M       (rdata2M),
    .stall         (stall),
    .bus           (bus_if),
    .load_data     (load_data),
    .load_valid    (load_valid),
    .fault         (fault),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001:  return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // One legal access with a reactive bus: grant on REQ cycle gnt_wait+1,
  // response on WAIT cycle rv_wait+1.
  task automatic run_access(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int gnt_wait, input int rv_wait, input logic [31:0] rdata,
                            input logic [31:0] exp_data, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_mask);
    exp_t e;
    exp_t got;
    int   req_n;
    int   wait_n;
    int   stalls;
    logic granted;
    logic done;
    e.ld     = (op == OP_L);
    e.err    = ((gnt_wait + 1) + (rv_wait + 1)) > TO;
    e.data   = e.err ? 32'h0 : exp_data;
    e.reqs   = ((gnt_wait + 1) < TO) ? (gnt_wait + 1) : TO;
    e.stalls = e.err ? (1 + TO) : (1 + (gnt_wait + 1) + (rv_wait + 1));
    sb_q.push_back(e);

    @(negedge clk);
    valid_m = 1'b1; instr_opcodeM = op; funct3M = f3; ALUResultM = addr; rdata2M = rs2;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
    #1;
    check_eq({name, ":stall_idle"}, 32'(stall), 32'd1);
    stalls = 1; req_n = 0; wait_n = 0; granted = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
      #1;
      if (stall) begin
        stalls++;
        if (bus_if.mem_req) begin
          req_n++;
          if (req_n == 1) begin
            check_eq({name, ":addr"}, bus_if.mem_addr, addr & 32'hFFFF_FFFC);
            check_eq({name, ":we"}, 32'(bus_if.mem_we), 32'(op == OP_S));
            check_eq({name, ":wmask"}, 32'(bus_if.mem_wmask), 32'(exp_mask));
            if (op == OP_S) check_eq({name, ":wdata"}, bus_if.mem_wdata, exp_wdata);
          end
          if (req_n == gnt_wait + 1) begin
            bus_if.mem_gnt = 1'b1;
            granted = 1'b1;
          end
        end else if (granted) begin
          wait_n++;
          if (wait_n == rv_wait + 1) begin
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = rdata;
          end
        end
      end else begin
        done = 1'b1;
        got = sb_q.pop_front();
        check_eq({name, ":stall_cycles"}, 32'(stalls), 32'(got.stalls));
        check_eq({name, ":req_cycles"}, 32'(req_n), 32'(got.reqs));
        check_eq({name, ":load_valid"}, 32'(load_valid), 32'(got.ld & ~got.err));
        check_eq({name, ":bus_err"}, 32'(bus_err), 32'(got.err));
        check_eq({name, ":req_done"}, 32'(bus_if.mem_req), 32'd0);
        if (got.ld || got.err) check_eq({name, ":load_data"}, load_data, got.data);
      end
    end
    if (!done) check_eq({name, ":completion"}, 32'd0, 32'd1);
  endtask

  // Misaligned or illegal access: one-cycle fault, no stall, no request.
  task automatic run_fault(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr);
    @(negedge clk);
    valid_m = 1'b1; instr_opcodeM = op; funct3M = f3; ALUResultM = addr;
    #1;
    check_eq({name, ":fault"}, 32'(fault), 32'd1);
    check_eq({name, ":stall"}, 32'(stall), 32'd0);
    check_eq({name, ":req"}, 32'(bus_if.mem_req), 32'd0);
    @(negedge clk);
    valid_m = 1'b0;
    #1;
    check_eq({name, ":fault_clear"}, 32'(fault), 32'd0);
    check_eq({name, ":req_after"}, 32'(bus_if.mem_req), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [2:0]  f3;
    logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};

    rst = 1'b0; valid_m = 1'b0; instr_opcodeM = 7'h00; funct3M = 3'b000;
    ALUResultM = 32'h0; rdata2M = 32'h0;
    bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("rst:stall", 32'(stall), 32'd0);
    check_eq("rst:req", 32'(bus_if.mem_req), 32'd0);
    check_eq("rst:we", 32'(bus_if.mem_we), 32'd0);
    check_eq("rst:load_valid", 32'(load_valid), 32'd0);
    check_eq("rst:bus_err", 32'(bus_err), 32'd0);
    check_eq("rst:fault", 32'(fault), 32'd0);
    check_eq("rst:load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_access("lw_best", OP_L, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 4'b0000);
    run_access("lb_neg", OP_L, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80112233, 32'hFFFFFF80, 32'h0, 4'b0000);
    run_access("lbu", OP_L, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80112233, 32'h00000080, 32'h0, 4'b0000);
    run_access("sh_hi", OP_S, 3'b001, 32'h202, 32'h0000ABCD, 1, 0, 32'h0, 32'h0, 32'hABCDABCD, 4'b1100);

    run_fault("lw_mis", OP_L, 3'b010, 32'h101);
    run_fault("ld_ill", OP_L, 3'b011, 32'h100);
    run_fault("sh_mis", OP_S, 3'b001, 32'h201);
    run_fault("st_ill", OP_S, 3'b100, 32'h200);

    for (int i = 0; i < 8; i++) begin
      f3 = ld_f3[i % 5];
      a  = 32'h400 + 32'(i * 16) + 32'($urandom_range(0, 3));
      if (f3 == 3'b010) a[1:0] = 2'b00;
      if (f3 == 3'b001 || f3 == 3'b101) a[0] = 1'b0;
      w  = $urandom;
      run_access("ld_mix", OP_L, f3, a, 32'h0, $urandom_range(0, 2), $urandom_range(0, 2), w,
                 model_load(f3, a[1:0], w), 32'h0, 4'b0000);
    end

    for (int i = 0; i < 6; i++) begin
      f3 = st_f3[i % 3];
      a  = 32'h800 + 32'(i * 8) + 32'($urandom_range(0, 3));
      if (f3 == 3'b010) a[1:0] = 2'b00;
      if (f3 == 3'b001) a[0] = 1'b0;
      w  = $urandom;
      run_access("st_mix", OP_S, f3, a, w, $urandom_range(0, 2), $urandom_range(0, 2), 32'h0,
                 32'h0, model_wdata(f3, w), model_mask(f3, a[1:0]));
    end

    run_access("to_nogrant", OP_L, 3'b010, 32'h500, 32'h0, 1000, 0, 32'h0, 32'h0, 32'h0, 4'b0000);
    run_access("to_rv_wins", OP_L, 3'b010, 32'h504, 32'h0, 0, 6, 32'h13572468, 32'h13572468, 32'h0, 4'b0000);
    run_access("to_wait", OP_L, 3'b010, 32'h508, 32'h0, 0, 7, 32'h55AA55AA, 32'h0, 32'h0, 4'b0000);
    run_access("lw_pre_rst", OP_L, 3'b010, 32'h300, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 32'h0, 4'b0000);

    // Reset in WAIT, then a stray response after release.
    @(negedge clk);
    valid_m = 1'b1; instr_opcodeM = OP_L; funct3M = 3'b010; ALUResultM = 32'h300;
    @(negedge clk);
    #1;
    check_eq("mrst:req", 32'(bus_if.mem_req), 32'd1);
    bus_if.mem_gnt = 1'b1;
    @(negedge clk);
    bus_if.mem_gnt = 1'b0;
    #1;
    check_eq("mrst:wait_stall", 32'(stall), 32'd1);
    valid_m = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("mrst:stall", 32'(stall), 32'd0);
    check_eq("mrst:req0", 32'(bus_if.mem_req), 32'd0);
    check_eq("mrst:load_data", load_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = 32'hCAFEF00D;
    #1;
    check_eq("mrst:stray_stall", 32'(stall), 32'd0);
    @(negedge clk);
    bus_if.mem_rvalid = 1'b0;
    #1;
    check_eq("mrst:stray_data", load_data, 32'd0);
    check_eq("mrst:stray_valid", 32'(load_valid), 32'd0);
    check_eq("mrst:stray_err", 32'(bus_err), 32'd0);
    check_eq("mrst:stray_req", 32'(bus_if.mem_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
